seg_pattern_reader: RTL and testbench

SEG_PATTERN_READER -- requirements
Module: seg_pattern_reader

---
 rtl/seg_pattern_reader.sv | 179 +++++++++++++++++
 tb/tb_seg_pattern_reader.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_pattern_reader.sv
// seg_pattern_reader
//   Samples a 7-segment pattern every clock, waits until it has been stable
//   for STABLE_CYCLES samples, decodes it to a hex digit and offers the
//   result on a valid/ready output. Blank patterns produce no result but
//   re-arm repeat suppression; unknown lit patterns are reported as errors.
//
// Configuration macro:
//   SEG_ACTIVE_LOW_EN  - when defined, seg is inverted before sampling
//                        (0 = lit segment, all-ones = blank).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   seg[6:0]   in   segment pattern {g,f,e,d,c,b,a}
//   out_ready  in   consumer accepts result when high with out_valid
//   out_valid  out  result pending
//   out_value  out  decoded hex digit
//   out_err    out  pending result is an unknown non-blank pattern
//   ovf        out  sticky: a result was dropped while one was pending
//   digit_cnt  out  accepted handshakes, wraps at 256

module seg_pattern_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [3:0] out_value,
    output logic       out_err,
    output logic       ovf,
    output logic [7:0] digit_cnt
);

    typedef enum logic [1:0] {TRACK, FIRE, HOLD} state_t;

    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

    // {hit, digit}; hit=0 means the pattern is not in the hex table
    function automatic logic [4:0] f_decode(input logic [6:0] p);
        case (p)
            7'h3F: return {1'b1, 4'h0};
            7'h06: return {1'b1, 4'h1};
            7'h5B: return {1'b1, 4'h2};
            7'h4F: return {1'b1, 4'h3};
            7'h66: return {1'b1, 4'h4};
            7'h6D: return {1'b1, 4'h5};
            7'h7D: return {1'b1, 4'h6};
            7'h07: return {1'b1, 4'h7};
            7'h7F: return {1'b1, 4'h8};
            7'h6F: return {1'b1, 4'h9};
            7'h77: return {1'b1, 4'hA};
            7'h7C: return {1'b1, 4'hB};
            7'h39: return {1'b1, 4'hC};
            7'h5E: return {1'b1, 4'hD};
            7'h79: return {1'b1, 4'hE};
            7'h71: return {1'b1, 4'hF};
            default: return 5'b0;
        endcase
    endfunction

    logic [6:0] w_seg_in;
`ifdef SEG_ACTIVE_LOW_EN
    assign w_seg_in = ~seg;
`else
    assign w_seg_in = seg;
`endif

    state_t     r_state, w_nxt_state;
    logic [6:0] r_seg_q;
    logic [3:0] r_stab_cnt;
    logic       r_done;       // current pattern has already been fired
    logic [6:0] r_eval_pat;   // pattern captured for the FIRE cycle
    logic       r_last_vld;
    logic [6:0] r_last_pat;
    logic       r_valid;
    logic [3:0] r_value;
    logic       r_err;
    logic       r_ovf;
    logic [7:0] r_cnt;

    logic       w_changed, w_trig, w_hs;
    logic [4:0] w_dec;
    logic       w_nxt_valid, w_nxt_err, w_nxt_ovf, w_nxt_last_vld;
    logic [3:0] w_nxt_value;
    logic [6:0] w_nxt_last_pat;

    assign w_changed = (w_seg_in != r_seg_q);
    // Fires once per held pattern; the saturated count alone cannot tell
    // a fresh arrival from a long hold, hence r_done.
    assign w_trig    = (r_stab_cnt == STAB_MAX) && !r_done;
    assign w_hs      = r_valid && out_ready;
    assign w_dec     = f_decode(r_eval_pat);

    // Sampling and stability tracking
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seg_q    <= 7'h00;
            r_stab_cnt <= 4'd0;
            r_done     <= 1'b0;
            r_eval_pat <= 7'h00;
        end else begin
            r_seg_q <= w_seg_in;
            if (w_changed)
                r_stab_cnt <= 4'd1;
            else if (r_stab_cnt != STAB_MAX)
                r_stab_cnt <= r_stab_cnt + 4'd1;
            r_done <= w_changed ? 1'b0 : (r_done | w_trig);
            if (w_trig)
                r_eval_pat <= r_seg_q;
        end
    end

    // FSM / result state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= TRACK;
            r_valid    <= 1'b0;
            r_value    <= 4'h0;
            r_err      <= 1'b0;
            r_ovf      <= 1'b0;
            r_cnt      <= 8'd0;
            r_last_vld <= 1'b0;
            r_last_pat <= 7'h00;
        end else begin
            r_state    <= w_nxt_state;
            r_valid    <= w_nxt_valid;
            r_value    <= w_nxt_value;
            r_err      <= w_nxt_err;
            r_ovf      <= w_nxt_ovf;
            r_cnt      <= r_cnt + {7'd0, w_hs};
            r_last_vld <= w_nxt_last_vld;
            r_last_pat <= w_nxt_last_pat;
        end
    end

    // Next-state and result evaluation. FIRE is the single evaluation
    // cycle; it can occur while a result is still pending, in which case
    // the new result is dropped unless the pending one is accepted now.
    always_comb begin
        w_nxt_valid    = r_valid && !w_hs;
        w_nxt_value    = r_value;
        w_nxt_err      = r_err;
        w_nxt_ovf      = r_ovf;
        w_nxt_last_vld = r_last_vld;
        w_nxt_last_pat = r_last_pat;

        if (r_state == FIRE) begin
            if (r_eval_pat == 7'h00) begin
                w_nxt_last_vld = 1'b0;
            end else if (!(r_last_vld && (r_last_pat == r_eval_pat))) begin
                w_nxt_last_vld = 1'b1;
                w_nxt_last_pat = r_eval_pat;
                if (r_valid && !out_ready) begin
                    w_nxt_ovf = 1'b1;
                end else begin
                    w_nxt_valid = 1'b1;
                    w_nxt_value = w_dec[4] ? w_dec[3:0] : 4'h0;
                    w_nxt_err   = !w_dec[4];
                end
            end
        end

        if (w_trig)
            w_nxt_state = FIRE;
        else if (w_nxt_valid)
            w_nxt_state = HOLD;
        else
            w_nxt_state = TRACK;
    end

    assign out_valid = r_valid;
    assign out_value = r_value;
    assign out_err   = r_err;
    assign ovf       = r_ovf;
    assign digit_cnt = r_cnt;

endmodule

// File: tb/tb_seg_pattern_reader.sv
// Scoreboard bench for seg_pattern_reader: a run-length reference model
// predicts results, a monitor compares every cycle.
module tb_seg_pattern_reader;

    localparam int S = 4;
`ifdef SEG_ACTIVE_LOW_EN
    localparam logic [6:0] INV = 7'h7F;
`else
    localparam logic [6:0] INV = 7'h00;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] seg = INV;
    logic       out_ready = 1'b0;
    logic       out_valid, out_err, ovf;
    logic [3:0] out_value;
    logic [7:0] digit_cnt;

    seg_pattern_reader #(.STABLE_CYCLES(S)) dut (
        .clk(clk), .reset(reset), .seg(seg), .out_ready(out_ready),
        .out_valid(out_valid), .out_value(out_value), .out_err(out_err),
        .ovf(ovf), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [6:0] TBL [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int         m_run = 0;
    logic [6:0] m_cur = 7'h00;
    int         m_last = -1;
    bit         m_pend = 0;
    int         m_ovf = 0;
    int         m_cnt = 0;
    int         cyc = 0;
    int         dq_due [$];
    logic [6:0] dq_pat [$];
    logic [4:0] exp_q [$];   // {err, value}

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 16; i++)
            if (TBL[i] == p) return {1'b0, 4'(i)};
        return {1'b1, 4'h0};
    endfunction

    task automatic model_clear();
        m_run = 0; m_cur = 7'h00; m_last = -1; m_pend = 0;
        m_ovf = 0; m_cnt = 0;
        dq_due.delete(); dq_pat.delete(); exp_q.delete();
    endtask

    always @(posedge clk) begin : model
        bit hs, loaded;
        logic [6:0] p;
        if (reset) begin
            model_clear();
        end else begin
            hs = m_pend && out_ready;
            loaded = 0;
            // a pattern stable for S samples is judged two edges later
            while (dq_due.size() > 0 && dq_due[0] == cyc) begin
                void'(dq_due.pop_front());
                p = dq_pat.pop_front();
                if (p == 7'h00) m_last = -1;
                else if (m_last != int'(p)) begin
                    m_last = int'(p);
                    if (m_pend && !hs) m_ovf = 1;
                    else begin
                        loaded = 1;
                        exp_q.push_back(ref_decode(p));
                    end
                end
            end
            if (hs) m_cnt = (m_cnt + 1) % 256;
            m_pend = loaded ? 1'b1 : (m_pend && !hs);
            p = seg ^ INV;
            if (p != m_cur) begin m_cur = p; m_run = 1; end
            else m_run++;
            if (m_run == S) begin dq_due.push_back(cyc + 2); dq_pat.push_back(p); end
        end
        cyc++;
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!reset) begin
            chk("out_valid", int'(out_valid), int'(m_pend));
            chk("ovf", int'(ovf), m_ovf);
            chk("digit_cnt", int'(digit_cnt), m_cnt);
            if (out_valid) begin
                if (exp_q.size() == 0)
                    chk("exp_queue_size", exp_q.size(), 1);
                else begin
                    chk("out_value", int'(out_value), int'(exp_q[0][3:0]));
                    chk("out_err", int'(out_err), int'(exp_q[0][4]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // rmode: 0 ready low, 1 ready high, 2 random ready
    task automatic hold(input logic [6:0] p, input int n, input int rmode);
        for (int i = 0; i < n; i++) begin
            seg = p ^ INV;
            out_ready = (rmode == 1) || (rmode == 2 && $urandom_range(0, 2) != 0);
            @(posedge clk);
            #2;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, int'(out_valid), 0);
        chk({tag, "_value"}, int'(out_value), 0);
        chk({tag, "_err"}, int'(out_err), 0);
        chk({tag, "_ovf"}, int'(ovf), 0);
        chk({tag, "_cnt"}, int'(digit_cnt), 0);
    endtask

    // called at posedge+2; reset is raised between edges
    task automatic do_reset(input int n);
        reset = 1'b1;
        #1;
        check_zero("rst_async");
        model_clear();
        repeat (n) @(posedge clk);
        #2;
        reset = 1'b0;
    endtask

    initial begin
        logic [6:0] prev, p;
        int r;
        repeat (2) @(posedge clk);
        #2;
        check_zero("rst_init");
        reset = 1'b0;

        // single digit, ready high
        hold(7'h5B, 12, 1);
        // toggling then settling
        for (int i = 0; i < 4; i++) begin hold(7'h06, 2, 1); hold(7'h4F, 2, 1); end
        hold(7'h4F, 10, 1);
        // long stall, overflow while pending, then release
        hold(7'h77, 20, 0);
        hold(7'h7C, 10, 0);
        hold(7'h7C, 6, 1);
        // blank re-arms repeat, long hold reports once
        hold(7'h3F, 8, 1); hold(7'h00, 8, 1); hold(7'h3F, 8, 1);
        hold(7'h3F, 30, 1);
        // error pattern held, reset while pending
        hold(7'h55, 10, 0);
        do_reset(2);
        // pattern present across reset release
        hold(7'h66, 10, 1);
        // handshake coinciding with a new evaluation
        hold(7'h07, 7, 0); hold(7'h07, 1, 1); hold(7'h39, 8, 1);

        prev = 7'h00;
        for (int k = 0; k < 300; k++) begin
            r = $urandom_range(0, 99);
            if (r < 50)      p = TBL[$urandom_range(0, 15)];
            else if (r < 65) p = 7'h00;
            else if (r < 80) p = prev;
            else             p = 7'($urandom_range(0, 127));
            hold(p, $urandom_range(1, 9), ($urandom_range(0, 3) == 0) ? 0 : 2);
            prev = p;
            if (k == 150) do_reset(3);
        end

        hold(7'h00, 20, 1);
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
